// File: rtl/pwm_cmd_sequencer.sv
// UART byte-stream command parser driving the PWM compare/enable bank.
// Frames are SYNC,CMD,VAL,CHK with CHK = CMD ^ VAL.
module pwm_cmd_sequencer #(
  parameter int          NUM_CH         = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  RESET_COMPARE  = 8'd128
) (
  input  logic                  CLK50MHZ,
  input  logic                  reset_s,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_err,
  output logic [NUM_CH*8-1:0]   pwm_compare_o,
  output logic [NUM_CH-1:0]     pwm_enable_o,
  output logic                  busy_o,
  output logic                  cmd_ok_o,
  output logic                  cmd_err_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GET_CMD,
    GET_VAL,
    GET_CHK
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, val_q;
  logic              cmd_ld, val_ld;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [7:0]        cmp_q [NUM_CH];
  logic [7:0]        cmp_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic              ok_d, err_d, apply;
  logic [3:0]        opc, chan;
  logic              chan_ok, frame_ok;
  logic [15:0]       val_ext;
  logic              expired;

  assign opc     = cmd_q[7:4];
  assign chan    = cmd_q[3:0];
  assign chan_ok = (32'(chan) < NUM_CH);
  assign val_ext = {8'h00, val_q};
  assign expired = (state_q != IDLE) && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Checksum, opcode range and, for per-channel opcodes, channel range.
  always_comb begin
    frame_ok = 1'b0;
    if (rx_data == (cmd_q ^ val_q)) begin
      unique case (1'b1)
        (opc == 4'h1): frame_ok = chan_ok;
        (opc == 4'h2): frame_ok = 1'b1;
        (opc == 4'h3): frame_ok = 1'b1;
        (opc == 4'h4): frame_ok = chan_ok;
        default:       frame_ok = 1'b0;
      endcase
    end
  end

  // Next-state, byte latching strobes, pulses and timeout counter.
  always_comb begin
    state_d = state_q;
    cmd_ld  = 1'b0;
    val_ld  = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    apply   = 1'b0;
    cnt_d   = cnt_q + TW'(1);
    if (rx_err) begin
      state_d = IDLE;
      err_d   = 1'b1;
      cnt_d   = '0;
    end else if (rx_valid) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = GET_CMD;
        end
        GET_CMD: begin
          cmd_ld  = 1'b1;
          state_d = GET_VAL;
        end
        GET_VAL: begin
          val_ld  = 1'b1;
          state_d = GET_CHK;
        end
        GET_CHK: begin
          state_d = IDLE;
          apply   = frame_ok;
          ok_d    = frame_ok;
          err_d   = !frame_ok;
        end
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      state_d = IDLE;
      err_d   = 1'b1;
      cnt_d   = '0;
    end
    if (state_q == IDLE && !(rx_valid && !rx_err)) cnt_d = '0;
  end

  // Command effect on compare values and enable mask.
  always_comb begin
    en_d = en_q;
    for (int i = 0; i < NUM_CH; i++) cmp_d[i] = cmp_q[i];
    if (apply) begin
      unique case (1'b1)
        (opc == 4'h1): begin
          for (int i = 0; i < NUM_CH; i++)
            if (chan == 4'(i)) cmp_d[i] = val_q;
        end
        (opc == 4'h2): en_d = val_ext[NUM_CH-1:0];
        (opc == 4'h3): begin
          for (int i = 0; i < NUM_CH; i++) cmp_d[i] = val_q;
        end
        (opc == 4'h4): begin
          for (int i = 0; i < NUM_CH; i++)
            if (chan == 4'(i)) en_d[i] = !en_q[i];
        end
        default: en_d = en_q;
      endcase
    end
  end

  // FSM state, timeout counter and registered status outputs.
  always_ff @(posedge CLK50MHZ or posedge reset_s) begin
    if (reset_s) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_o    <= 1'b0;
      cmd_ok_o  <= 1'b0;
      cmd_err_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_o    <= (state_d != IDLE);
      cmd_ok_o  <= ok_d;
      cmd_err_o <= err_d;
    end
  end

  // Frame field latches and PWM settings.
  always_ff @(posedge CLK50MHZ or posedge reset_s) begin
    if (reset_s) begin
      cmd_q <= '0;
      val_q <= '0;
      en_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= RESET_COMPARE;
    end else begin
      if (cmd_ld) cmd_q <= rx_data;
      if (val_ld) val_q <= rx_data;
      en_q <= en_d;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign pwm_compare_o[8*c+7:8*c] = cmp_q[c];
  end

  assign pwm_enable_o = en_q;

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Directed bench for pwm_cmd_sequencer.
// Short timeout so the expiry path is reachable quickly.
module tb_pwm_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_s;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic [63:0] cmp;
  logic [7:0]  en;
  logic        busy, ok, err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ok   = 0;
  int n_err  = 0;

  pwm_cmd_sequencer #(
    .NUM_CH(8),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100),
    .RESET_COMPARE(8'd128)
  ) dut (
    .CLK50MHZ(clk),
    .reset_s(reset_s),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_err(rx_err),
    .pwm_compare_o(cmp),
    .pwm_enable_o(en),
    .busy_o(busy),
    .cmd_ok_o(ok),
    .cmd_err_o(err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (ok)  n_ok  <= n_ok + 1;
    if (err) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    int ok0, err0;
    bit seen;
    reset_s  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_err   = 1'b0;
    repeat (3) tick();
    reset_s = 1'b0;
    tick();

    chk("rst_cmp", cmp, 64'h8080_8080_8080_8080);
    chk("rst_en", {56'd0, en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_pulses", {62'd0, ok, err}, 64'd0);

    frame(8'hA5, 8'h14, 8'h40, 8'h54);
    chk("set4_ok", {63'd0, ok}, 64'd1);
    chk("set4_cmp", cmp, 64'h8080_8040_8080_8080);
    chk("set4_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("set4_okdrop", {62'd0, ok, err}, 64'd0);

    frame(8'hA5, 8'h20, 8'hF0, 8'hD0);
    chk("en_mask", {56'd0, en}, 64'hF0);
    frame(8'hA5, 8'h42, 8'h00, 8'h42);
    chk("en_toggle", {56'd0, en}, 64'hF4);
    chk("toggle_ok", {63'd0, ok}, 64'd1);

    frame(8'hA5, 8'h13, 8'h10, 8'h00);
    chk("badchk_pulse", {62'd0, ok, err}, 64'd1);
    chk("badchk_cmp", cmp, 64'h8080_8040_8080_8080);
    frame(8'hA5, 8'h19, 8'h10, 8'h09);
    chk("badch_pulse", {62'd0, ok, err}, 64'd1);
    chk("badch_cmp", cmp, 64'h8080_8040_8080_8080);
    chk("badch_en", {56'd0, en}, 64'hF4);
    tick();

    ok0  = n_ok;
    err0 = n_err;
    send(8'h00);
    send(8'hFF);
    chk("junk_busy", {63'd0, busy}, 64'd0);
    frame(8'hA5, 8'h30, 8'h7F, 8'h4F);
    chk("all_cmp", cmp, 64'h7F7F_7F7F_7F7F_7F7F);
    tick();
    chk("junk_okcnt", 64'(n_ok - ok0), 64'd1);
    chk("junk_errcnt", 64'(n_err - err0), 64'd0);

    send(8'hA5);
    send(8'h11);
    repeat (50) tick();
    chk("to_busy_mid", {63'd0, busy}, 64'd1);
    chk("to_noerr_mid", {63'd0, err}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("to_err", {63'd0, seen}, 64'd1);
    chk("to_busy_fall", {63'd0, busy}, 64'd0);
    frame(8'hA5, 8'h11, 8'h33, 8'h22);
    chk("after_to_ok", {63'd0, ok}, 64'd1);
    chk("after_to_cmp", cmp, 64'h7F7F_7F7F_7F7F_337F);

    send(8'hA5);
    send(8'h12);
    chk("abort_busy_pre", {63'd0, busy}, 64'd1);
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    chk("abort_err", {62'd0, ok, err}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);

    frame(8'hA5, 8'h31, 8'h05, 8'h34);
    send(8'hA5);
    send(8'h14);
    #3;
    reset_s = 1'b1;
    #2;
    chk("mrst_cmp", cmp, 64'h8080_8080_8080_8080);
    chk("mrst_en", {56'd0, en}, 64'd0);
    chk("mrst_flags", {61'd0, busy, ok, err}, 64'd0);
    tick();
    reset_s = 1'b0;
    tick();
    chk("mrst_after", {61'd0, busy, ok, err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
